// File: rtl/i2s_line_in_rx_pkg.sv
// Shared definitions for the I2S line-in receiver: FSM state encodings and
// channel identifiers carried on the LR clock.
package i2s_line_in_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } rx_state_t;

  localparam logic I2S_CH_LEFT  = 1'b0;
  localparam logic I2S_CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_line_in_rx_edge_sync.sv
// Brings the codec-driven bclk/lr/sdata into the clk domain and flags each
// synchronised bclk rising edge. lr_s/sdata_s are registered alongside bedge
// so that they describe the line state at the moment of that edge.
module i2s_line_in_rx_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  input  logic lr,
  input  logic sdata,
  output logic bedge,
  output logic lr_s,
  output logic sdata_s
);

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   bclk_prev;

  // Synchroniser chains, identical depth so all three lines stay aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync  <= '0;
      lr_sync    <= '0;
      sdata_sync <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lr_sync    <= {lr_sync[SYNC_STAGES-2:0], lr};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
    end
  end

  // Rising-edge detect on synced bclk, with lr/sdata registered in step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_prev <= 1'b0;
      bedge     <= 1'b0;
      lr_s      <= 1'b0;
      sdata_s   <= 1'b0;
    end else begin
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
      bedge     <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
      lr_s      <= lr_sync[SYNC_STAGES-1];
      sdata_s   <= sdata_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_line_in_rx.sv
// I2S receiver for the ADAU1761 ADC stream. Deserialises left/right words
// from the oversampled I2S lines and presents each complete L+R pair with a
// one-cycle sample_valid strobe; short words raise a one-cycle frame_err.
// Optional left peak meter is built when I2S_RX_PEAK_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first LR transition after reset
// SHIFT | capturing MSB-first bits of the current channel word
// HOLD  | word complete, remaining slot bits ignored until LR toggles
module i2s_line_in_rx
  import i2s_line_in_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int PEAK_DECAY  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lr,
  input  logic                  i2s_sdata,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  sample_valid,
  output logic                  frame_err
`ifdef I2S_RX_PEAK_EN
  ,
  output logic [3:0]            peak_l
`endif
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                  bedge;
  logic                  lr_s;
  logic                  sdata_s;
  logic                  lr_prev;
  logic                  lr_primed;
  logic                  lr_chg;
  rx_state_t             state;
  logic                  chan;
  logic [CNT_W-1:0]      bitcnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [DATA_WIDTH-1:0] hold_l;
  logic                  l_ok;
  logic                  word_done;
  logic                  pair_done;

  i2s_line_in_rx_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .bclk   (i2s_bclk),
    .lr     (i2s_lr),
    .sdata  (i2s_sdata),
    .bedge  (bedge),
    .lr_s   (lr_s),
    .sdata_s(sdata_s)
  );

  // The very first bedge only seeds lr_prev, so it can never look like a toggle
  assign lr_chg     = bedge & lr_primed & (lr_s != lr_prev);
  assign shreg_next = {shreg[DATA_WIDTH-2:0], sdata_s};
  assign word_done  = bedge & ~lr_chg & (state == ST_SHIFT) & (bitcnt == LAST_BIT);
  assign pair_done  = word_done & (chan != I2S_CH_LEFT) & l_ok;

  // LR history sampled on every bit-clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lr_prev   <= 1'b0;
      lr_primed <= 1'b0;
    end else if (bedge) begin
      lr_prev   <= lr_s;
      lr_primed <= 1'b1;
    end
  end

  // Receive FSM: word capture, L/R pairing and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      chan         <= I2S_CH_LEFT;
      bitcnt       <= '0;
      shreg        <= '0;
      hold_l       <= '0;
      l_ok         <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (lr_chg) begin
        // The toggle edge carries the previous word's LSB, so no bit is taken here
        if (state == ST_SHIFT) begin
          frame_err <= 1'b1;
          l_ok      <= 1'b0;
        end
        state  <= ST_SHIFT;
        chan   <= lr_s;
        bitcnt <= '0;
        shreg  <= '0;
      end else if (bedge && state == ST_SHIFT) begin
        shreg <= shreg_next;
        if (bitcnt == LAST_BIT) begin
          state <= ST_HOLD;
          if (chan == I2S_CH_LEFT) begin
            hold_l <= shreg_next;
            l_ok   <= 1'b1;
          end else begin
            if (l_ok) begin
              sample_l     <= hold_l;
              sample_r     <= shreg_next;
              sample_valid <= 1'b1;
            end
            l_ok <= 1'b0;
          end
        end else begin
          bitcnt <= bitcnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef I2S_RX_PEAK_EN
  localparam int DEC_W = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;
  localparam logic [DEC_W-1:0] DECAY_RELOAD = DEC_W'(PEAK_DECAY - 1);

  logic [DATA_WIDTH-1:0] mag_l;
  logic [3:0]            cand;
  logic [DEC_W-1:0]      decay_cnt;

  // Saturated magnitude of the left word about to be published
  always_comb begin
    mag_l = hold_l;
    if (hold_l[DATA_WIDTH-1]) begin
      if (hold_l == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
        mag_l = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        mag_l = -hold_l;
      end
    end
  end

  assign cand = mag_l[DATA_WIDTH-2 -: 4];

  // Peak hold with slow decay: one step down per PEAK_DECAY frames without a new max
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_l    <= 4'd0;
      decay_cnt <= DECAY_RELOAD;
    end else if (pair_done) begin
      if (cand > peak_l) begin
        peak_l    <= cand;
        decay_cnt <= DECAY_RELOAD;
      end else if (decay_cnt == '0) begin
        if (peak_l != 4'd0) begin
          peak_l <= peak_l - 4'd1;
        end
        decay_cnt <= DECAY_RELOAD;
      end else begin
        decay_cnt <= decay_cnt - DEC_W'(1);
      end
    end
  end
`else
  logic unused_peak_cfg;
  logic unused_pair_done;
  assign unused_peak_cfg  = ^PEAK_DECAY;
  assign unused_pair_done = pair_done;
`endif

endmodule
